// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the pipelined half-adder-array approximate multiplier.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    EXACT   = 2'd0,
    OR_SUM  = 2'd1,
    CARRY_A = 2'd2,
    ELIM    = 2'd3
  } apx_mode_e;

  // apx_cols must be able to express every column 0..2*width, inclusive.
  function automatic int colw(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/ha_cell_apx.sv
// One half-adder cell whose sum/carry can be replaced by a cheaper approximation.
module ha_cell_apx
  import approx_mul_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      apx_en,
  input  apx_mode_e mode,
  output logic      s,
  output logic      co
);

  always_comb begin
    // NOTE: exact outputs are assigned first so every path drives s/co and no latch is inferred.
    s  = a ^ b;
    co = a & b;
    if (apx_en) begin
      case (mode)
        OR_SUM:  begin s = a | b; co = 1'b0; end
        CARRY_A: begin s = 1'b0;  co = a;    end
        ELIM:    begin s = 1'b0;  co = 1'b0; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/approx_mul_ha_pipe.sv
// Three-stage WIDTH x WIDTH approximate multiplier built from paired-row half-adder arrays,
// with an exact shadow product and saturating absolute-error statistics.
module approx_mul_ha_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 32,
  parameter int COLW  = colw(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [1:0]           mode,
  input  logic [COLW-1:0]      apx_cols,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [2*WIDTH-1:0]   p_exact,
  input  logic                 stats_clr,
  output logic [ACC_W-1:0]     err_acc,
  output logic [ACC_W-1:0]     sample_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam int NA = WIDTH / 2;
  localparam int NC = WIDTH - 1;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // Whole pipeline advances in lock-step; a stalled output freezes every stage.
  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // ---------------- S1: operands and configuration ----------------
  logic             v1_q;
  logic [WIDTH-1:0] x1_q, y1_q;
  apx_mode_e        mode1_q;
  logic [COLW-1:0]  cols1_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
    if (rst) begin
      v1_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      mode1_q <= EXACT;
      cols1_q <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      x1_q    <= x;
      y1_q    <= y;
      mode1_q <= apx_mode_e'(mode);
      cols1_q <= apx_cols;
    end
  end

  // ---------------- S1 -> S2: half-adder arrays ----------------
  logic [NA-1:0]         t0_d, bmsb_d, t0_q, bmsb_q;
  logic [NA-1:0][NC-1:0] s_d, co_d, s_q, co_q;

  for (genvar k = 0; k < NA; k++) begin : g_arr
    assign t0_d[k]   = x1_q[2*k] & y1_q[0];
    assign bmsb_d[k] = x1_q[2*k+1] & y1_q[WIDTH-1];
    for (genvar j = 0; j < NC; j++) begin : g_cell
      localparam int C = 2 * k + j + 1;
      ha_cell_apx u_cell (
        .a      (x1_q[2*k] & y1_q[j+1]),
        .b      (x1_q[2*k+1] & y1_q[j]),
        .apx_en (cols1_q > COLW'(C)),
        .mode   (mode1_q),
        .s      (s_d[k][j]),
        .co     (co_d[k][j])
      );
    end
  end

  logic          v2_q;
  logic [PW-1:0] pe2_q;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so p/p_exact read 0 straight out of reset.
    if (rst) begin
      v2_q   <= 1'b0;
      t0_q   <= '0;
      bmsb_q <= '0;
      s_q    <= '0;
      co_q   <= '0;
      pe2_q  <= '0;
    end else if (en) begin
      v2_q   <= v1_q;
      t0_q   <= t0_d;
      bmsb_q <= bmsb_d;
      s_q    <= s_d;
      co_q   <= co_d;
      pe2_q  <= PW'(x1_q) * PW'(y1_q);
    end
  end

  // ---------------- S2 -> S3: weighted reduction ----------------
  logic [PW-1:0] p_d;

  always_comb begin
    p_d = '0;
    for (int k = 0; k < NA; k++) begin
      p_d = p_d + (PW'(t0_q[k]) << (2*k)) + (PW'(bmsb_q[k]) << (2*k + WIDTH));
      for (int j = 0; j < NC; j++) begin
        p_d = p_d + (PW'(s_q[k][j]) << (2*k + j + 1)) + (PW'(co_q[k][j]) << (2*k + j + 2));
      end
    end
  end

  logic          v3_q;
  logic [PW-1:0] p_q, pe3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q  <= 1'b0;
      p_q   <= '0;
      pe3_q <= '0;
    end else if (en) begin
      v3_q  <= v2_q;
      p_q   <= p_d;
      pe3_q <= pe2_q;
    end
  end

  assign out_valid = v3_q;
  assign p         = p_q;
  assign p_exact   = pe3_q;

  // ---------------- Error statistics ----------------
  logic             hs;
  logic [PW-1:0]    abs_err;
  logic [SW-1:0]    err_sum;
  logic [ACC_W-1:0] err_d, err_q, cnt_d, cnt_q;

  assign hs = v3_q & out_ready;

  always_comb begin
    abs_err = (pe3_q >= p_q) ? (pe3_q - p_q) : (p_q - pe3_q);
    err_sum = SW'(err_q) + SW'(abs_err);
    err_d   = err_q;
    cnt_d   = cnt_q;
    // A coincident clear discards the sample being delivered.
    if (stats_clr) begin
      err_d = '0;
      cnt_d = '0;
    end else if (hs) begin
      err_d = (err_sum > SW'(ACC_MAX)) ? ACC_MAX : err_sum[ACC_W-1:0];
      if (cnt_q != ACC_MAX) cnt_d = cnt_q + ACC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_acc    = err_q;
  assign sample_cnt = cnt_q;

endmodule
